// File: rtl/gba_gpu_vram_arbiter.sv
// gba_gpu_vram_arbiter
// Single-port VRAM arbiter shared by the CPU/DMA port and the BG and OBJ
// fetchers of the drawer. Grants are combinational from the current requests
// and the registered state, so one access can issue every cycle. Read data
// goes back to whichever requester owns the read one cycle after its grant.
//
// Optional build: define GBA_VRAM_ARB_STATS_EN to add a saturating
// CPU-stall cycle counter (cpu_stall_cnt) with a clear input (stats_clr).
//
// Mode FSM
//   state   | meaning
//   NORMAL  | drawer idle, priority CPU > OBJ > BG
//   BLOCKED | drawer on a visible line, priority OBJ > BG > CPU
//   In either state, a CPU request that has waited CPU_MAX_WAIT cycles wins.
module gba_gpu_vram_arbiter #(
  parameter int AW           = 14,
  parameter int CPU_MAX_WAIT = 7
) (
  input  logic          fclk,
  input  logic          reset,
  input  logic          block_mode,
  // CPU / DMA requester
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  // BG fetch requester
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic          bg_gnt,
  // OBJ fetch requester
  input  logic          obj_req,
  input  logic [AW-1:0] obj_addr,
  output logic          obj_gnt,
  // VRAM port
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  // read return
  output logic [31:0]   rdata,
  output logic          rvalid_cpu,
  output logic          rvalid_bg,
  output logic          rvalid_obj,
`ifdef GBA_VRAM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   cpu_stall_cnt,
`endif
  output logic          cpu_stalled
);

  typedef enum logic {NORMAL = 1'b0, BLOCKED = 1'b1} mode_t;

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  mode_t      state;
  logic [3:0] wait_cnt;
  logic       cpu_force;
  logic       rv_cpu_q;
  logic       rv_bg_q;
  logic       rv_obj_q;

  assign cpu_force = (wait_cnt >= MAX_WAIT);

  // Mode FSM: follows block_mode one cycle late.
  always_ff @(posedge fclk) begin
    if (reset) begin
      state <= NORMAL;
    end else begin
      case (state)
        NORMAL:  if (block_mode)  state <= BLOCKED;
        BLOCKED: if (!block_mode) state <= NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

  // Grant select; nothing is granted while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    bg_gnt  = 1'b0;
    obj_gnt = 1'b0;
    if (!reset) begin
      if (cpu_req && (cpu_force || state == NORMAL)) cpu_gnt = 1'b1;
      else if (obj_req)                              obj_gnt = 1'b1;
      else if (bg_req)                               bg_gnt  = 1'b1;
      else if (cpu_req)                              cpu_gnt = 1'b1;
    end
  end

  assign cpu_stalled = cpu_req && !cpu_gnt && !reset;

  // Steer the granted requester onto the VRAM port; idle port is all zero.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = 32'h0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_be    = cpu_be;
      ram_wdata = cpu_wdata;
    end else if (obj_gnt) begin
      ram_addr  = obj_addr;
    end else if (bg_gnt) begin
      ram_addr  = bg_addr;
    end
  end

  // CPU wait counter: counts stalled cycles, saturates, clears on grant or release.
  always_ff @(posedge fclk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (cpu_gnt || !cpu_req) begin
      wait_cnt <= 4'd0;
    end else if (cpu_stalled && wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Read ownership tags, one cycle behind the grant to match RAM latency.
  always_ff @(posedge fclk) begin
    if (reset) begin
      rv_cpu_q <= 1'b0;
      rv_bg_q  <= 1'b0;
      rv_obj_q <= 1'b0;
    end else begin
      rv_cpu_q <= cpu_gnt && !cpu_we;
      rv_bg_q  <= bg_gnt;
      rv_obj_q <= obj_gnt;
    end
  end

  // Reset masks a read that was already in flight when reset arrived.
  assign rvalid_cpu = rv_cpu_q && !reset;
  assign rvalid_bg  = rv_bg_q  && !reset;
  assign rvalid_obj = rv_obj_q && !reset;
  assign rdata      = (rvalid_cpu || rvalid_bg || rvalid_obj) ? ram_rdata : 32'h0;

`ifdef GBA_VRAM_ARB_STATS_EN
  // Saturating count of CPU stall cycles.
  always_ff @(posedge fclk) begin
    if (reset || stats_clr) begin
      cpu_stall_cnt <= 16'h0;
    end else if (cpu_stalled && cpu_stall_cnt != 16'hFFFF) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'h1;
    end
  end
`endif

endmodule
